// File: rtl/demux_16bit_assembler.sv
// Assembles a 16-bit word from single bits placed by index, then hands it off with valid/ready.
// Optional DEMUX_AUTO_INDEX_EN replaces in_sel with an internal wrapping position counter.
module demux_16bit_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic [3:0]  in_sel,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [15:0] out_word,
  input  logic        out_ready,
  output logic [15:0] fill_mask,
  output logic        dup_err
);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [15:0] mask_q, mask_d;
  logic        dup_q, dup_d;
  logic [3:0]  idx;

`ifdef DEMUX_AUTO_INDEX_EN
  logic [3:0] cnt_q, cnt_d;
  logic       unused_sel;

  assign idx        = cnt_q;
  assign unused_sel = ^in_sel;
`else
  assign idx = in_sel;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    dup_d   = dup_q;
`ifdef DEMUX_AUTO_INDEX_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StFill: begin
        if (flush) begin
          // Flush wins over a same-cycle input transfer.
          word_d = '0;
          mask_d = '0;
          dup_d  = 1'b0;
`ifdef DEMUX_AUTO_INDEX_EN
          cnt_d  = '0;
`endif
        end else if (in_valid) begin
          word_d[idx] = in_bit;
          mask_d[idx] = 1'b1;
`ifdef DEMUX_AUTO_INDEX_EN
          cnt_d = cnt_q + 4'd1;
`else
          if (mask_q[idx]) dup_d = 1'b1;
`endif
          if (mask_d == 16'hFFFF) state_d = StFull;
        end
      end
      StFull: begin
        if (out_ready) begin
          state_d = StFill;
          word_d  = '0;
          mask_d  = '0;
          dup_d   = 1'b0;
`ifdef DEMUX_AUTO_INDEX_EN
          cnt_d   = '0;
`endif
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      word_q  <= '0;
      mask_q  <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      dup_q   <= dup_d;
    end
  end

`ifdef DEMUX_AUTO_INDEX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign in_ready  = (state_q == StFill);
  assign out_valid = (state_q == StFull);
  assign out_word  = word_q;
  assign fill_mask = mask_q;
  assign dup_err   = dup_q;

endmodule

// File: tb/tb_demux_16bit_assembler.sv
// Self-checking bench for demux_16bit_assembler: vector table, corner sequences, random vs model.
// Define DEMUX_AUTO_INDEX_EN for both RTL and bench to exercise the counter-indexed build.
module tb_demux_16bit_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_bit, flush, out_ready;
  logic [3:0]  in_sel;
  logic        in_ready, out_valid, dup_err;
  logic [15:0] out_word, fill_mask;

  int tests  = 0;
  int failed = 0;

  demux_16bit_assembler dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_sel   (in_sel),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_word (out_word),
    .out_ready(out_ready),
    .fill_mask(fill_mask),
    .dup_err  (dup_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        b;
    logic [3:0]  s;
    logic        f;
    logic        r;
    logic [15:0] e_word;
    logic [15:0] e_mask;
    logic        e_valid;
    logic        e_dup;
  } vec_t;

  vec_t tbl[17];

  // Reference model: word as an integer, written positions as a mask.
  logic [15:0] m_word, m_mask;
  logic        m_full, m_dup;
  int          m_cnt;

  function automatic logic [34:0] snap();
    return {out_valid, in_ready, dup_err, fill_mask, out_word};
  endfunction

  function automatic logic [34:0] pack(input logic v, input logic d, input logic [15:0] m,
                                       input logic [15:0] w);
    return {v, ~v, d, m, w};
  endfunction

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got {valid,ready,dup,mask,word}=%h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic [3:0] s, input logic f,
                       input logic r);
    in_valid  = v;
    in_bit    = b;
    in_sel    = s;
    flush     = f;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_word = '0;
    m_mask = '0;
    m_dup  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_step();
    int i;
    if (!m_full) begin
      if (flush) model_clear();
      else if (in_valid) begin
`ifdef DEMUX_AUTO_INDEX_EN
        i = m_cnt;
`else
        i = int'(in_sel);
        if (((m_mask >> i) & 16'd1) != 16'd0) m_dup = 1'b1;
`endif
        m_word = (m_word & ~(16'd1 << i)) | (16'(in_bit) << i);
        m_mask = m_mask | (16'd1 << i);
        m_cnt  = (m_cnt + 1) % 16;
        if (m_mask == 16'hFFFF) m_full = 1'b1;
      end
    end else if (out_ready) begin
      model_clear();
      m_full = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] pat;
    logic [15:0] msk;

    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    #2;
    check("reset_state", snap(), pack(1'b0, 1'b0, 16'h0000, 16'h0000));
    #1 rst = 1'b0;

    // Table: write A5C3 in index order, then hand off.
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      msk = 16'((32'd1 << (i + 1)) - 32'd1);
      tbl[i].v = 1'b1;  tbl[i].b = pat[i];  tbl[i].s = 4'(i);
      tbl[i].f = 1'b0;  tbl[i].r = 1'b1;
      tbl[i].e_word = pat & msk;  tbl[i].e_mask = msk;
      tbl[i].e_valid = (i == 15);  tbl[i].e_dup = 1'b0;
    end
    tbl[16].v = 1'b0;  tbl[16].b = 1'b0;  tbl[16].s = 4'd0;  tbl[16].f = 1'b0;  tbl[16].r = 1'b1;
    tbl[16].e_word = 16'h0;  tbl[16].e_mask = 16'h0;  tbl[16].e_valid = 1'b0;  tbl[16].e_dup = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].f, tbl[i].r);
      tick();
      check($sformatf("table_%0d", i), snap(),
            pack(tbl[i].e_valid, tbl[i].e_dup, tbl[i].e_mask, tbl[i].e_word));
    end

`ifndef DEMUX_AUTO_INDEX_EN
    // Duplicate write to index 3, then hold FULL with out_ready low.
    drive(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    tick();
    check("dup_after_rewrite", snap(), pack(1'b0, 1'b1, 16'h0008, 16'h0000));
    for (int i = 0; i < 16; i++) begin
      if (i != 3) begin
        drive(1'b1, 1'b1, 4'(i), 1'b0, 1'b0);
        tick();
      end
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 4'd3, (c == 2), 1'b0);
      tick();
      check($sformatf("full_hold_%0d", c), snap(), pack(1'b1, 1'b1, 16'hFFFF, 16'hFFF7));
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    check("dup_handoff_clear", snap(), pack(1'b0, 1'b0, 16'h0000, 16'h0000));
`endif

    // Eight writes then flush with a same-cycle transfer.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 4'(i), 1'b0, 1'b0);
      tick();
    end
    check("partial_8", snap(), pack(1'b0, 1'b0, 16'h00FF, 16'h00FF));
    drive(1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
    tick();
    check("flush_discard", snap(), pack(1'b0, 1'b0, 16'h0000, 16'h0000));

    // Async reset while FULL, then first edge after release accepts a bit.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 4'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("full_before_rst", snap(), pack(1'b1, 1'b0, 16'hFFFF, 16'hFFFF));
    #3 rst = 1'b1;
    #1 check("async_rst_full", snap(), pack(1'b0, 1'b0, 16'h0000, 16'h0000));
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    check("first_edge_after_rst", snap(), pack(1'b0, 1'b0, 16'h0001, 16'h0001));

`ifdef DEMUX_AUTO_INDEX_EN
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i % 2 == 0), 4'hF, 1'b0, 1'b0);
      tick();
    end
    check("auto_5555", snap(), pack(1'b1, 1'b0, 16'hFFFF, 16'h5555));
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    tick();
    check("auto_wrap_to_0", snap(), pack(1'b0, 1'b0, 16'h0001, 16'h0001));
`endif

    // Randomized run against the reference model.
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    model_clear();
    m_full = 1'b0;
    #1 rst = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
            ($urandom_range(0, 39) == 0), 1'($urandom));
      model_step();
      tick();
      check($sformatf("random_%0d", n), snap(), pack(m_full, m_dup, m_mask, m_word));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
